// File: rtl/disp_source_arbiter.sv
// Chooses whether the 7-seg display shows the temperature stream or the setpoint editor.
// A setpoint change takes over the display for a hold window, and an alarm blinks the temperature.
module disp_source_arbiter #(
    parameter int DATA_W       = 16,
    parameter int HOLD_CYCLES  = 150_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [DATA_W-1:0] temp_data,
    output logic              temp_ready,
    input  logic              set_valid,
    input  logic [DATA_W-1:0] set_data,
    output logic              set_ready,
    input  logic              alarm,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_blank,
    output logic [1:0]        disp_src
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_TEMP = 2'b01;
    localparam logic [1:0] SRC_SETP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEMP = 2'd1,
        SETP = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shadow;
    logic                seen;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [BLINK_W-1:0]  blink_cnt;

    logic                temp_xfer;
    logic                set_xfer;
    logic [DATA_W-1:0]   shadow_next;
    logic                seen_next;

    // A temperature accepted this cycle must already count when leaving the hold window.
    assign temp_xfer   = temp_valid && temp_ready;
    assign set_xfer    = set_valid && set_ready;
    assign shadow_next = temp_xfer ? temp_data : shadow;
    assign seen_next   = seen || temp_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            seen       <= 1'b0;
            hold_cnt   <= '0;
            blink_cnt  <= '0;
            temp_ready <= 1'b0;
            set_ready  <= 1'b0;
            disp_data  <= '0;
            disp_blank <= 1'b1;
            disp_src   <= SRC_NONE;
        end else begin
            temp_ready <= !temp_xfer;
            set_ready  <= !set_xfer;
            if (temp_xfer) begin
                shadow <= temp_data;
                seen   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    blink_cnt <= '0;
                    if (set_xfer) begin
                        state      <= SETP;
                        hold_cnt   <= HOLD_LOAD;
                        disp_data  <= set_data;
                        disp_blank <= 1'b0;
                        disp_src   <= SRC_SETP;
                    end else if (temp_xfer) begin
                        state      <= TEMP;
                        disp_data  <= temp_data;
                        disp_blank <= 1'b0;
                        disp_src   <= SRC_TEMP;
                    end
                end

                TEMP: begin
                    if (set_xfer) begin
                        state      <= SETP;
                        hold_cnt   <= HOLD_LOAD;
                        blink_cnt  <= '0;
                        disp_data  <= set_data;
                        disp_blank <= 1'b0;
                        disp_src   <= SRC_SETP;
                    end else begin
                        disp_data <= shadow_next;
                        if (!alarm) begin
                            blink_cnt  <= '0;
                            disp_blank <= 1'b0;
                        end else if (blink_cnt == BLINK_LAST) begin
                            blink_cnt  <= '0;
                            disp_blank <= !disp_blank;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end

                SETP: begin
                    blink_cnt <= '0;
                    // A set transfer on the expiry cycle extends the hold rather than leaving.
                    if (set_xfer) begin
                        hold_cnt  <= HOLD_LOAD;
                        disp_data <= set_data;
                    end else if (hold_cnt == '0) begin
                        disp_data <= shadow_next;
                        if (seen_next) begin
                            state      <= TEMP;
                            disp_blank <= 1'b0;
                            disp_src   <= SRC_TEMP;
                        end else begin
                            state      <= IDLE;
                            disp_blank <= 1'b1;
                            disp_src   <= SRC_NONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    disp_blank <= 1'b1;
                    disp_src   <= SRC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Directed and randomized checks of disp_source_arbiter against a deadline/phase-based
// reference model of the display source rules.
module tb_disp_source_arbiter;

    localparam int DW    = 16;
    localparam int HOLD  = 20;
    localparam int BLINK = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          temp_valid;
    logic [DW-1:0] temp_data;
    logic          temp_ready;
    logic          set_valid;
    logic [DW-1:0] set_data;
    logic          set_ready;
    logic          alarm;
    logic [DW-1:0] disp_data;
    logic          disp_blank;
    logic [1:0]    disp_src;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: mode 0 none, 1 temperature, 2 setpoint
    int            cyc = 0;
    int            m_mode;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_shadow;
    bit            m_seen;
    bit            m_blank;
    bit            m_tr;
    bit            m_sr;
    int            deadline;
    int            origin;

    disp_source_arbiter #(
        .DATA_W      (DW),
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .temp_valid(temp_valid),
        .temp_data (temp_data),
        .temp_ready(temp_ready),
        .set_valid (set_valid),
        .set_data  (set_data),
        .set_ready (set_ready),
        .alarm     (alarm),
        .disp_data (disp_data),
        .disp_blank(disp_blank),
        .disp_src  (disp_src)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        bit tx;
        bit sx;
        bit entered;
        cyc++;
        if (reset) begin
            m_mode   = 0;
            m_data   = '0;
            m_shadow = '0;
            m_seen   = 0;
            m_blank  = 1;
            m_tr     = 0;
            m_sr     = 0;
        end else begin
            tx      = temp_valid && m_tr;
            sx      = set_valid && m_sr;
            m_tr    = !tx;
            m_sr    = !sx;
            entered = 0;
            if (tx) begin
                m_shadow = temp_data;
                m_seen   = 1;
            end
            if (sx) begin
                m_mode   = 2;
                m_data   = set_data;
                deadline = cyc + HOLD;
            end else if (m_mode == 2 && cyc >= deadline) begin
                m_data = m_shadow;
                if (m_seen) begin
                    m_mode  = 1;
                    entered = 1;
                end else begin
                    m_mode = 0;
                end
            end else if (m_mode == 0 && tx) begin
                m_mode  = 1;
                m_data  = m_shadow;
                entered = 1;
            end else if (m_mode == 1) begin
                m_data = m_shadow;
            end
            if (m_mode == 0) begin
                m_blank = 1;
            end else if (m_mode == 2) begin
                m_blank = 0;
            end else if (entered || !alarm) begin
                origin  = cyc;
                m_blank = 0;
            end else begin
                m_blank = (((cyc - origin) / BLINK) % 2) != 0;
            end
        end
    endtask

    task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        expectVal({tag, ".data"},  32'(disp_data),  32'(m_data));
        expectVal({tag, ".blank"}, 32'(disp_blank), 32'(m_blank));
        expectVal({tag, ".src"},   32'(disp_src),   32'(m_mode));
        expectVal({tag, ".tready"}, 32'(temp_ready), 32'(m_tr));
        expectVal({tag, ".sready"}, 32'(set_ready),  32'(m_sr));
    endtask

    task automatic applyStimulus(input bit rst, input bit tv, input logic [DW-1:0] td,
                                 input bit sv, input logic [DW-1:0] sd, input bit al,
                                 input string tag);
        reset      = rst;
        temp_valid = tv;
        temp_data  = td;
        set_valid  = sv;
        set_data   = sd;
        alarm      = al;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic idleSteps(input int n, input bit al, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0, al, tag);
    endtask

    initial begin
        reset = 1; temp_valid = 0; temp_data = '0; set_valid = 0; set_data = '0; alarm = 0;
        @(negedge clk);

        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, "reset0");
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, "reset1");
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, "release");
        expectVal("rel.blank", 32'(disp_blank), 32'd1);
        expectVal("rel.src",   32'(disp_src),   32'd0);
        expectVal("rel.data",  32'(disp_data),  32'd0);
        expectVal("rel.readys", {30'd0, temp_ready, set_ready}, 32'd3);

        applyStimulus(0, 1, 16'h1D00, 0, 16'h0, 0, "temp1");
        expectVal("temp1.src",  32'(disp_src),  32'd1);
        expectVal("temp1.data", 32'(disp_data), 32'h1D00);
        expectVal("temp1.tready_low", 32'(temp_ready), 32'd0);
        idleSteps(1, 0, "temp1.idle");
        expectVal("temp1.tready_back", 32'(temp_ready), 32'd1);

        applyStimulus(0, 1, 16'h1E00, 1, 16'h1B00, 0, "both");
        expectVal("both.src",  32'(disp_src),  32'd2);
        expectVal("both.data", 32'(disp_data), 32'h1B00);
        idleSteps(HOLD - 1, 0, "hold1");
        expectVal("hold1.still_setp", 32'(disp_src), 32'd2);
        idleSteps(1, 0, "hold1.end");
        expectVal("hold1.src",  32'(disp_src),  32'd1);
        expectVal("hold1.data", 32'(disp_data), 32'h1E00);

        applyStimulus(0, 0, 16'h0, 1, 16'h1B00, 0, "set2");
        idleSteps(14, 0, "hold2a");
        applyStimulus(0, 0, 16'h0, 1, 16'h1C00, 0, "set3");
        expectVal("set3.data", 32'(disp_data), 32'h1C00);
        idleSteps(HOLD - 1, 0, "hold2b");
        expectVal("hold2.still_setp", 32'(disp_src), 32'd2);
        idleSteps(1, 0, "hold2.end");
        expectVal("hold2.src", 32'(disp_src), 32'd1);

        for (int k = 1; k <= 13; k++) begin
            applyStimulus(0, 0, 16'h0, 0, 16'h0, 1, "blink");
            expectVal("blink.pattern", 32'(disp_blank), 32'((k / BLINK) % 2));
        end
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, "alarm_drop");
        expectVal("alarm_drop.blank", 32'(disp_blank), 32'd0);

        applyStimulus(0, 0, 16'h0, 1, 16'h1A00, 1, "setp_alarm");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 16'h0, 0, 16'h0, 1, "setp_alarm.hold");
            expectVal("setp_alarm.noblink", 32'(disp_blank), 32'd0);
        end

        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, "midreset");
        expectVal("midreset.src",   32'(disp_src),   32'd0);
        expectVal("midreset.blank", 32'(disp_blank), 32'd1);
        expectVal("midreset.data",  32'(disp_data),  32'd0);
        idleSteps(HOLD + 5, 0, "post_reset");
        expectVal("post_reset.src", 32'(disp_src), 32'd0);
        applyStimulus(0, 1, 16'h1900, 0, 16'h0, 0, "newtemp");
        expectVal("newtemp.src",  32'(disp_src),  32'd1);
        expectVal("newtemp.data", 32'(disp_data), 32'h1900);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(3) == 0), 16'($urandom),
                          ($urandom_range(15) == 0), 16'($urandom),
                          ($urandom_range(9) < 6), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
